hc_gate_bank: RTL and testbench
===============================

Name: hc_gate_bank

Overview:
- Parametrised, clocked successor to the quad 2-input NOR gate block.
- CH channels of 2-input gates with a runtime-selectable logic function, input synchronisers, and registered outputs.
- A blanking state machine suppresses glitches after reset and after every function change.
- A change detector with a saturating event counter supports on-board debug.

Parameters:
- CH, 4, number of gate channels (>=1).
- SYNC_STAGES, 2, synchroniser flops on A and B (1..3).
- BLANK_CYC, 3, cycles Y is held low after reset or a mode load. Must be >= SYNC_STAGES; elaboration error otherwise.
- CNT_W, 8, width of the change counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  CH  gate input A, one bit per channel.
- B  input  CH  gate input B, one bit per channel.
- MODE  input  3  function select, sampled only when MODE_LD=1.
- MODE_LD  input  1  mode load strobe.
- OE  input  1  output enable, active high.
- Y  output  CH  registered gate outputs.
- Y_VALID  output  1  high when Y reflects the current mode and inputs.
- CHG  output  1  one-cycle pulse when Y changed while valid.
- CHG_CNT  output  CNT_W  saturating count of CHG pulses.

Behaviour:
- Reset (asynchronous, RST=1):
  - Outputs: Y=0, Y_VALID=0, CHG=0, CHG_CNT=0.
  - Internal: synchroniser flops=0, mode register=3'b000 (NOR), state=BLANK, blank counter=BLANK_CYC.
- Mode encoding, applied per bit i:
  - 000 NOR, 001 NAND, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 BUF A.
  - All codes are legal.
- Data path:
  - A and B each pass through SYNC_STAGES flops.
  - The Y register then loads f(mode, A_s, B_s) when OE=1, or 0 when OE=0.
  - Input-to-Y latency in RUN: SYNC_STAGES+1 edges (3 by default).
- OE is sampled. OE=0 drives Y to 0 at the next edge; Y_VALID is unaffected.
- State machine, states BLANK and RUN:
  - BLANK: Y=0, Y_VALID=0, counter decrements each edge. On the edge where the counter equals 1, go to RUN; Y loads the function and Y_VALID becomes 1 on that same edge.
  - Y_VALID therefore rises exactly BLANK_CYC edges after reset deassertion or after the MODE_LD edge.
  - RUN: MODE_LD=1 latches MODE, reloads counter=BLANK_CYC, clears CHG_CNT, and goes to BLANK. Y=0 and Y_VALID=0 from that edge.
  - MODE_LD=1 while in BLANK: latch the new MODE, reload the counter (blanking restarts), and clear CHG_CNT.
  - MODE_LD held high continuously keeps the block in BLANK.
- Change detector:
  - CHG=1 for one cycle following the edge where Y_VALID was 1 before and after, and Y changed value.
  - OE-induced changes count.
  - The BLANK->RUN transition never produces CHG.
- CHG_CNT:
  - Increments by 1 on each edge where CHG is being asserted; it saturates at 2^CNT_W-1 and does not wrap.
  - MODE_LD clear has priority over a simultaneous increment.
- Reset mid-operation (any state) returns everything to the reset values, including mode=NOR.

Optional Feature:
- Macro: HC_GATE_BANK_PARITY_EN.
- Defined: adds output port Y_PAR (1 bit), registered, equal to the XOR-reduce of the next Y value.
  - Updates on the same edge as Y, so it always matches Y.
  - Forced 0 in BLANK and at reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release, A=4'h0, B=4'h0, MODE_LD=0, OE=1 -> Y_VALID rises at the 3rd edge with Y=4'hF; CHG=0; CHG_CNT=0.
- In RUN, set A=4'h5 -> Y=4'hA exactly 3 edges later; one-cycle CHG pulse; CHG_CNT=1.
- MODE=3'b100, MODE_LD pulsed one cycle, with A=4'h5, B=4'h3 -> Y=0 and Y_VALID=0 for 3 cycles, then Y=4'h6, Y_VALID=1; CHG_CNT=0; no CHG at the transition.
- OE dropped to 0 with Y=4'h6 -> Y=0 at the next edge, Y_VALID stays 1, CHG pulses; OE=1 restores Y=4'h6 with a second CHG.
- CNT_W=2, toggle A[1] six times in RUN -> CHG_CNT reads 1, 2, 3, 3, 3, 3 (saturates).
- MODE_LD with XOR, then RST pulsed during BLANK -> all outputs 0. After release, mode is NOR and Y_VALID rises BLANK_CYC edges later.

Source files
------------

// File: rtl/hc_gate_bank_if.sv
// rtl/hc_gate_bank_if.sv - gate bank signal bundle; y_par present when HC_GATE_BANK_PARITY_EN is defined
interface hc_gate_bank_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]    a;
    logic [CH-1:0]    b;
    logic [2:0]       mode;
    logic             mode_ld;
    logic             oe;
    logic [CH-1:0]    y;
    logic             y_valid;
    logic             chg;
    logic [CNT_W-1:0] chg_cnt;
`ifdef HC_GATE_BANK_PARITY_EN
    logic             y_par;

    modport master (
        output a, b, mode, mode_ld, oe,
        input  y, y_valid, chg, chg_cnt, y_par
    );
    modport slave (
        input  a, b, mode, mode_ld, oe,
        output y, y_valid, chg, chg_cnt, y_par
    );
`else
    modport master (
        output a, b, mode, mode_ld, oe,
        input  y, y_valid, chg, chg_cnt
    );
    modport slave (
        input  a, b, mode, mode_ld, oe,
        output y, y_valid, chg, chg_cnt
    );
`endif
endinterface

// File: rtl/hc_gate_bank.sv
// rtl/hc_gate_bank.sv - CH-channel selectable-function gate bank with blanking FSM and change counter
// Optional registered parity output y_par enabled by HC_GATE_BANK_PARITY_EN.
module hc_gate_bank #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int BLANK_CYC   = 3,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    hc_gate_bank_if.slave   bus
);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC);
    localparam logic [BW-1:0] CNT_ONE    = BW'(1);

    if (CH < 1) begin : g_bad_ch
        $error("hc_gate_bank: CH must be >= 1");
    end
    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("hc_gate_bank: SYNC_STAGES must be 1..3");
    end
    if (BLANK_CYC < SYNC_STAGES) begin : g_bad_blank
        $error("hc_gate_bank: BLANK_CYC must be >= SYNC_STAGES");
    end

    typedef enum logic {ST_BLANK, ST_RUN} state_t;

    state_t           state, state_n;
    logic [BW-1:0]    blank_cnt, blank_cnt_n;
    logic [2:0]       mode_q, mode_n;
    logic [CH-1:0]    y_q, y_n;
    logic             yv_q, yv_n;
    logic             chg_q, chg_n;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_n;
    logic [CH-1:0]    gate;

    logic [CH-1:0] a_sync [SYNC_STAGES];
    logic [CH-1:0] b_sync [SYNC_STAGES];

    function automatic logic [CH-1:0] gate_fn(input logic [2:0] m,
                                              input logic [CH-1:0] ia,
                                              input logic [CH-1:0] ib);
        case (m)
            3'b000:  return ~(ia | ib);
            3'b001:  return ~(ia & ib);
            3'b010:  return ia & ib;
            3'b011:  return ia | ib;
            3'b100:  return ia ^ ib;
            3'b101:  return ~(ia ^ ib);
            3'b110:  return ~ia;
            default: return ia;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '0;
                b_sync[i] <= '0;
            end
        end else begin
            a_sync[0] <= bus.a;
            b_sync[0] <= bus.b;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                b_sync[i] <= b_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BLANK;
            blank_cnt <= BLANK_INIT;
            mode_q    <= 3'b000;
            y_q       <= '0;
            yv_q      <= 1'b0;
            chg_q     <= 1'b0;
            chg_cnt_q <= '0;
        end else begin
            state     <= state_n;
            blank_cnt <= blank_cnt_n;
            mode_q    <= mode_n;
            y_q       <= y_n;
            yv_q      <= yv_n;
            chg_q     <= chg_n;
            chg_cnt_q <= chg_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        blank_cnt_n = blank_cnt;
        mode_n      = mode_q;
        y_n         = y_q;
        yv_n        = yv_q;
        chg_cnt_n   = chg_cnt_q;
        gate        = bus.oe ? gate_fn(mode_q, a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]) : '0;

        if (chg_q && chg_cnt_q != '1) begin
            chg_cnt_n = chg_cnt_q + CNT_W'(1);
        end

        // A mode load restarts blanking and its counter clear overrides any pending increment.
        case (state)
            ST_BLANK: begin
                y_n  = '0;
                yv_n = 1'b0;
                if (bus.mode_ld) begin
                    mode_n      = bus.mode;
                    blank_cnt_n = BLANK_INIT;
                    chg_cnt_n   = '0;
                end else if (blank_cnt == CNT_ONE) begin
                    state_n = ST_RUN;
                    y_n     = gate;
                    yv_n    = 1'b1;
                end else begin
                    blank_cnt_n = blank_cnt - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (bus.mode_ld) begin
                    state_n     = ST_BLANK;
                    mode_n      = bus.mode;
                    blank_cnt_n = BLANK_INIT;
                    chg_cnt_n   = '0;
                    y_n         = '0;
                    yv_n        = 1'b0;
                end else begin
                    y_n  = gate;
                    yv_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_BLANK;
            end
        endcase

        chg_n = yv_q && yv_n && (y_n != y_q);
    end

    assign bus.y       = y_q;
    assign bus.y_valid = yv_q;
    assign bus.chg     = chg_q;
    assign bus.chg_cnt = chg_cnt_q;

`ifdef HC_GATE_BANK_PARITY_EN
    logic y_par_q;

    // y_n is forced to zero while blanking, so its parity is zero there too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_par_q <= 1'b0;
        end else begin
            y_par_q <= ^y_n;
        end
    end

    assign bus.y_par = y_par_q;
`endif
endmodule

// File: tb/tb_hc_gate_bank.sv
// tb/tb_hc_gate_bank.sv - scoreboard bench for hc_gate_bank (default and CNT_W=2 instances)
module tb_hc_gate_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hc_gate_bank_if #(.CH(4), .CNT_W(8)) bus1 ();
    hc_gate_bank_if #(.CH(4), .CNT_W(2)) bus2 ();

    assign bus2.a       = bus1.a;
    assign bus2.b       = bus1.b;
    assign bus2.mode    = bus1.mode;
    assign bus2.mode_ld = bus1.mode_ld;
    assign bus2.oe      = bus1.oe;

    hc_gate_bank #(.CH(4), .SYNC_STAGES(2), .BLANK_CYC(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    hc_gate_bank #(.CH(4), .SYNC_STAGES(2), .BLANK_CYC(3), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [3:0] y;
        logic       v;
        logic       chg;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        int         idx;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_step   = 0;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the following rising edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] m,
                        input logic ld, input logic oe,
                        input logic [3:0] ey, input logic ev, input logic ec, input logic [7:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus1.a       = a;
        bus1.b       = b;
        bus1.mode    = m;
        bus1.mode_ld = ld;
        bus1.oe      = oe;
        e.y    = ey;
        e.v    = ev;
        e.chg  = ec;
        e.cnt  = ecnt;
        e.cnt2 = (ecnt > 8'd3) ? 2'd3 : ecnt[1:0];
        e.idx  = n_step;
        n_step++;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("y",        e.idx, {4'h0, bus1.y},       {4'h0, e.y});
                chk("y_valid",  e.idx, {7'h0, bus1.y_valid}, {7'h0, e.v});
                chk("chg",      e.idx, {7'h0, bus1.chg},     {7'h0, e.chg});
                chk("chg_cnt",  e.idx, bus1.chg_cnt,         e.cnt);
                chk("chg_cnt2", e.idx, {6'h0, bus2.chg_cnt}, {6'h0, e.cnt2});
`ifdef HC_GATE_BANK_PARITY_EN
                chk("y_par",    e.idx, {7'h0, bus1.y_par},   {7'h0, ^e.y});
`endif
            end
        end
    end

    initial begin
        logic [3:0] a_cur;
        logic [3:0] y_old;
        logic [3:0] y_new;

        bus1.a       = 4'h0;
        bus1.b       = 4'h0;
        bus1.mode    = 3'b000;
        bus1.mode_ld = 1'b0;
        bus1.oe      = 1'b1;

        // reset state
        step(1, 4'h0, 4'h0, 3'b000, 0, 1, 4'h0, 0, 0, 8'd0);
        step(1, 4'h0, 4'h0, 3'b000, 0, 1, 4'h0, 0, 0, 8'd0);
        // release: valid at 3rd edge, NOR(0,0)=F
        step(0, 4'h0, 4'h0, 3'b000, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h0, 4'h0, 3'b000, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h0, 4'h0, 3'b000, 0, 1, 4'hF, 1, 0, 8'd0);
        step(0, 4'h0, 4'h0, 3'b000, 0, 1, 4'hF, 1, 0, 8'd0);
        // A=5 reaches Y three edges later
        step(0, 4'h5, 4'h0, 3'b000, 0, 1, 4'hF, 1, 0, 8'd0);
        step(0, 4'h5, 4'h0, 3'b000, 0, 1, 4'hF, 1, 0, 8'd0);
        step(0, 4'h5, 4'h0, 3'b000, 0, 1, 4'hA, 1, 1, 8'd0);
        step(0, 4'h5, 4'h0, 3'b000, 0, 1, 4'hA, 1, 0, 8'd1);
        // load XOR: three blanked cycles, then 5^3=6 without CHG
        step(0, 4'h5, 4'h3, 3'b100, 1, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h6, 1, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h6, 1, 0, 8'd0);
        // OE off then on
        step(0, 4'h5, 4'h3, 3'b100, 0, 0, 4'h0, 1, 1, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 0, 4'h0, 1, 0, 8'd1);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h6, 1, 1, 8'd1);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h6, 1, 0, 8'd2);
        // reload XOR to clear counters before saturation run
        step(0, 4'h5, 4'h3, 3'b100, 1, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h6, 1, 0, 8'd0);
        // six toggles of A[1]: Y alternates 4/6, 2-bit counter saturates at 3
        a_cur = 4'h5;
        y_old = 4'h6;
        for (int k = 0; k < 6; k++) begin
            a_cur = a_cur ^ 4'h2;
            y_new = a_cur ^ 4'h3;
            step(0, a_cur, 4'h3, 3'b100, 0, 1, y_old, 1, 0, 8'(k));
            step(0, a_cur, 4'h3, 3'b100, 0, 1, y_old, 1, 0, 8'(k));
            step(0, a_cur, 4'h3, 3'b100, 0, 1, y_new, 1, 1, 8'(k));
            y_old = y_new;
        end
        step(0, a_cur, 4'h3, 3'b100, 0, 1, y_old, 1, 0, 8'd6);
        // reset during blanking returns mode to NOR
        step(0, 4'h5, 4'h3, 3'b100, 1, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(1, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(1, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h0, 0, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h8, 1, 0, 8'd0);
        step(0, 4'h5, 4'h3, 3'b100, 0, 1, 4'h8, 1, 0, 8'd0);

        @(posedge clk);
        #2;
        n_assert++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
